instruction_prefetch_queue: RTL and testbench

- Sits between the Avalon-MM instruction bus and the CPU decode/control path, upstream of the instruction register.
- Issues pipelined 32-bit word reads ahead of execution, one address per accepted command, and buffers up to DEPTH returned words with their fetch addresses.
- Presents the oldest buffered instruction to the core with a valid/ready handshake.
- On a redirect (taken branch, jump, trap), flushes all buffered words, drops responses to reads already in flight, and restarts fetching at the new PC.

---
 rtl/instruction_prefetch_queue_pkg.sv | 15 +
 rtl/avalon_mm_read.sv | 11 +
 rtl/instruction_fifo.sv | 60 ++++++
 rtl/instruction_prefetch_queue.sv | 129 ++++++++++++
 tb/tb_instruction_prefetch_queue.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package Types;

  typedef enum logic {
    FETCH_IDLE,
    FETCH_REQ
  } fetch_state_t;

  localparam int unsigned INSTRUCTION_BYTES = 4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/avalon_mm_read.sv
// Avalon-MM read-only host/agent bundle (pipelined reads with readdatavalid).
interface AvalonMmRead;
  logic [31:0] address;
  logic        read;
  logic        waitrequest;
  logic        readdatavalid;
  logic [31:0] agent_to_host;

  modport Host  (output address, read, input waitrequest, readdatavalid, agent_to_host);
  modport Agent (input address, read, output waitrequest, readdatavalid, agent_to_host);
endinterface

// File: rtl/instruction_fifo.sv
// Synchronous FIFO with registered storage, flush, and occupancy count.
module instruction_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head_ptr;
  logic [AW-1:0]    tail_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign valid   = (occupancy != '0);
  assign full    = (occupancy == FULL_COUNT);
  assign do_pop  = pop && valid;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[head_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_ptr  <= '0;
      tail_ptr  <= '0;
      occupancy <= '0;
      mem       <= '{default: '0};
    end else if (flush) begin
      head_ptr  <= '0;
      tail_ptr  <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) begin
        mem[tail_ptr] <= push_data;
        tail_ptr      <= tail_ptr + 1'b1;
      end
      if (do_pop) begin
        head_ptr <= head_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        occupancy <= occupancy + 1'b1;
      end else if (do_pop && !do_push) begin
        occupancy <= occupancy - 1'b1;
      end
    end
  end

endmodule

// File: rtl/instruction_prefetch_queue.sv
// Prefetches instruction words over Avalon-MM, buffers them with their PCs,
// and hands the oldest one to the core; redirects flush and restart fetching.
module instruction_prefetch_queue
  import Types::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  AvalonMmRead.Host         instruction_manager,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              ir_valid,
  output logic [31:0]       ir,
  output logic [31:0]       ir_pc,
  input  logic              ir_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  fetch_state_t state;
  fetch_state_t state_next;

  logic [31:0]   fetch_pc;
  logic [31:0]   redir_pc;
  logic          redir_pending;
  logic [CW-1:0] discard;
  logic [CW-1:0] discard_next;
  logic [CW-1:0] inflight;
  logic [CW-1:0] inflight_next;
  logic [CW-1:0] occupancy;
  logic [CW:0]   occ_est;
  logic [31:0]   resp_pc;
  logic          resp_pc_valid;

  logic accept;
  logic stalled;
  logic accept_live;
  logic accept_stale;
  logic keep;
  logic drop;
  logic pop;
  logic credit;

  assign instruction_manager.read    = (state == FETCH_REQ);
  assign instruction_manager.address = fetch_pc;

  assign accept       = (state == FETCH_REQ) && !instruction_manager.waitrequest;
  assign stalled      = (state == FETCH_REQ) && instruction_manager.waitrequest;
  assign accept_stale = accept && (redirect || redir_pending);
  assign accept_live  = accept && !redirect && !redir_pending;
  assign keep = instruction_manager.readdatavalid && resp_pc_valid && (discard == '0) && !redirect;
  assign drop = instruction_manager.readdatavalid && ((discard != '0) || redirect);
  assign pop  = ir_valid && ir_ready && !redirect;

  // Live in-flight reads are exactly the entries of the return-PC FIFO.
  instruction_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_return_pc (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (accept_live),
    .push_data (fetch_pc),
    .pop       (keep),
    .head      (resp_pc),
    .valid     (resp_pc_valid),
    .occupancy (inflight)
  );

  instruction_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (keep),
    .push_data ({instruction_manager.agent_to_host, resp_pc}),
    .pop       (pop),
    .head      ({ir, ir_pc}),
    .valid     (ir_valid),
    .occupancy (occupancy)
  );

  // Credit looks at next-cycle counters but never at ir_ready; a response landing
  // on a redirect edge is charged against the old stream via discard.
  always_comb begin
    inflight_next = redirect ? '0 : inflight + CW'(accept_live) - CW'(keep);
    discard_next  = discard + (redirect ? inflight : '0) + CW'(accept_stale) - CW'(drop);
    occ_est       = redirect ? '0 : {1'b0, occupancy} + (CW + 1)'(keep);
    credit        = (occ_est + {1'b0, inflight_next} < DEPTH_W) &&
                    ({1'b0, discard_next} + {1'b0, inflight_next} < DEPTH_W);

    state_next = state;
    unique case (state)
      FETCH_IDLE: if (credit) state_next = FETCH_REQ;
      FETCH_REQ:  if (accept && !credit) state_next = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= FETCH_IDLE;
      fetch_pc      <= RESET_PC;
      redir_pc      <= RESET_PC;
      redir_pending <= 1'b0;
      discard       <= '0;
    end else begin
      state   <= state_next;
      discard <= discard_next;
      // A stalled command keeps its address; the new PC is parked until it is accepted.
      if (redirect && stalled) begin
        redir_pending <= 1'b1;
        redir_pc      <= word_align(redirect_pc);
      end else if (redirect) begin
        redir_pending <= 1'b0;
        fetch_pc      <= word_align(redirect_pc);
      end else if (accept) begin
        redir_pending <= 1'b0;
        fetch_pc      <= redir_pending ? redir_pc : fetch_pc + INSTRUCTION_BYTES;
      end
    end
  end

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Directed bench for instruction_prefetch_queue with a behavioural Avalon agent.
module tb_instruction_prefetch_queue;

  localparam logic [31:0] XOR_KEY = 32'hA5A5A5A5;

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } pend_t;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ir_valid;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_ready;

  AvalonMmRead bus ();

  instruction_prefetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .instruction_manager (bus),
    .redirect            (redirect),
    .redirect_pc         (redirect_pc),
    .ir_valid            (ir_valid),
    .ir                  (ir),
    .ir_pc               (ir_pc),
    .ir_ready            (ir_ready)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  int unsigned lat;
  logic        stall_en;
  logic [31:0] stall_addr;

  pend_t       pend_q[$];
  logic [31:0] iss_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_ir_q[$];
  int unsigned pop_cyc_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Agent responds in command order 'lat' cycles after acceptance; also logs traffic.
  always @(negedge clk) begin
    if (!rst) begin
      pend_q.delete();
      bus.waitrequest   = 1'b0;
      bus.readdatavalid = 1'b0;
      bus.agent_to_host = '0;
    end else begin
      bus.readdatavalid = 1'b0;
      bus.agent_to_host = '0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        bus.readdatavalid = 1'b1;
        bus.agent_to_host = pend_q[0].addr ^ XOR_KEY;
        void'(pend_q.pop_front());
      end
      bus.waitrequest = stall_en && bus.read && (bus.address == stall_addr);
      if (bus.read && !bus.waitrequest) begin
        pend_q.push_back('{due: cyc + lat, addr: bus.address});
        if (!redirect) iss_q.push_back(bus.address);
      end
      if (ir_valid && ir_ready && !redirect) begin
        pop_pc_q.push_back(ir_pc);
        pop_ir_q.push_back(ir);
        pop_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int unsigned l, input logic rdy);
    rst      = 1'b0;
    lat      = l;
    ir_ready = rdy;
    tick(2);
    rst = 1'b1;
  endtask

  int unsigned mi;
  int unsigned mp;
  int unsigned c0;
  bit          seen;

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; ir_ready = 1'b1;
    lat = 1; stall_en = 1'b0; stall_addr = 32'h20;
    tick(3);

    // Reset values
    check("rst_read", bus.read, 1'b0);
    check("rst_address", bus.address, 32'h0);
    check("rst_ir_valid", ir_valid, 1'b0);
    check("rst_ir", ir, 32'h0);
    check("rst_ir_pc", ir_pc, 32'h0);

    // Streaming with zero-wait agent
    mi = iss_q.size(); mp = pop_pc_q.size();
    rst = 1'b1;
    tick(1);
    c0 = cyc;
    check("first_read", bus.read, 1'b1);
    check("first_addr", bus.address, 32'h0);
    tick(12);
    check("t1_n_iss", 32'(iss_q.size() - mi >= 6), 1);
    for (int k = 0; k < 6; k++) check("t1_addr", iss_q[mi + k], 32'(k * 4));
    check("t1_n_pop", 32'(pop_pc_q.size() - mp >= 5), 1);
    for (int k = 0; k < 5; k++) begin
      check("t1_ir_pc", pop_pc_q[mp + k], 32'(k * 4));
      check("t1_ir", pop_ir_q[mp + k], 32'(k * 4) ^ XOR_KEY);
      check("t1_pop_cycle", pop_cyc_q[mp + k], c0 + 2 + 32'(k));
    end

    // Back-pressure: exactly DEPTH reads, then one more per freed slot
    do_reset(1, 1'b0);
    mi = iss_q.size(); mp = pop_pc_q.size();
    tick(12);
    check("bp_read_low", bus.read, 1'b0);
    check("bp_n_iss", iss_q.size() - mi, 4);
    check("bp_ir_valid", ir_valid, 1'b1);
    check("bp_ir_pc", ir_pc, 32'h0);
    check("bp_ir", ir, XOR_KEY);
    ir_ready = 1'b1;
    tick(1);
    ir_ready = 1'b0;
    tick(8);
    check("bp_n_iss_after", iss_q.size() - mi, 5);
    check("bp_fifth_addr", iss_q[mi + 4], 32'h10);
    check("bp_read_low2", bus.read, 1'b0);
    check("bp_n_pop", pop_pc_q.size() - mp, 1);
    check("bp_head_pc", ir_pc, 32'h4);
    check("bp_head_ir", ir, 32'h4 ^ XOR_KEY);

    // Redirect with three reads in flight
    do_reset(3, 1'b1);
    tick(4);
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    mi = iss_q.size(); mp = pop_pc_q.size();
    tick(1);
    redirect = 1'b0;
    check("rd_ir_valid", ir_valid, 1'b0);
    check("rd_read", bus.read, 1'b1);
    check("rd_addr", bus.address, 32'h100);
    tick(15);
    check("rd_n_pop", 32'(pop_pc_q.size() - mp >= 3), 1);
    for (int k = 0; k < 3; k++) begin
      check("rd_iss", iss_q[mi + k], 32'h100 + 32'(k * 4));
      check("rd_ir_pc", pop_pc_q[mp + k], 32'h100 + 32'(k * 4));
      check("rd_ir", pop_ir_q[mp + k], (32'h100 + 32'(k * 4)) ^ XOR_KEY);
    end

    // Redirect while a command is stalled at 0x20
    stall_en = 1'b1; stall_addr = 32'h20;
    do_reset(1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(1);
      if (bus.read && bus.address == 32'h20) seen = 1'b1;
    end
    check("st_reached", 32'(seen), 1);
    tick(2);
    check("st_hold_read", bus.read, 1'b1);
    check("st_hold_addr", bus.address, 32'h20);
    redirect = 1'b1; redirect_pc = 32'h300;
    mi = iss_q.size(); mp = pop_pc_q.size();
    tick(1);
    redirect = 1'b0;
    check("st_post_read", bus.read, 1'b1);
    check("st_post_addr", bus.address, 32'h20);
    check("st_ir_valid", ir_valid, 1'b0);
    tick(1);
    check("st_post_addr2", bus.address, 32'h20);
    stall_en = 1'b0;
    tick(10);
    check("st_iss0", iss_q[mi], 32'h20);
    check("st_iss1", iss_q[mi + 1], 32'h300);
    check("st_iss2", iss_q[mi + 2], 32'h304);
    check("st_n_pop", 32'(pop_pc_q.size() - mp >= 3), 1);
    for (int k = 0; k < 3; k++) begin
      check("st_ir_pc", pop_pc_q[mp + k], 32'h300 + 32'(k * 4));
      check("st_ir", pop_ir_q[mp + k], (32'h300 + 32'(k * 4)) ^ XOR_KEY);
    end

    // Fetch PC wraps past the top of the address space
    check("wr_pre_valid", ir_valid, 1'b1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    mi = iss_q.size(); mp = pop_pc_q.size();
    tick(1);
    redirect = 1'b0;
    check("wr_ir_valid", ir_valid, 1'b0);
    check("wr_read", bus.read, 1'b1);
    check("wr_addr", bus.address, 32'hFFFF_FFF8);
    tick(10);
    check("wr_iss0", iss_q[mi], 32'hFFFF_FFF8);
    check("wr_iss1", iss_q[mi + 1], 32'hFFFF_FFFC);
    check("wr_iss2", iss_q[mi + 2], 32'h0000_0000);
    check("wr_iss3", iss_q[mi + 3], 32'h0000_0004);
    check("wr_pc0", pop_pc_q[mp], 32'hFFFF_FFF8);
    check("wr_pc1", pop_pc_q[mp + 1], 32'hFFFF_FFFC);
    check("wr_pc2", pop_pc_q[mp + 2], 32'h0000_0000);
    check("wr_ir0", pop_ir_q[mp], 32'h5A5A_5A5D);
    check("wr_ir1", pop_ir_q[mp + 1], 32'h5A5A_5A59);
    check("wr_ir2", pop_ir_q[mp + 2], 32'hA5A5_A5A5);

    // One-cycle reset with a full queue
    ir_ready = 1'b0;
    tick(10);
    check("mr_full_valid", ir_valid, 1'b1);
    check("mr_full_read", bus.read, 1'b0);
    rst = 1'b0;
    tick(1);
    check("mr_read", bus.read, 1'b0);
    check("mr_address", bus.address, 32'h0);
    check("mr_ir_valid", ir_valid, 1'b0);
    check("mr_ir", ir, 32'h0);
    check("mr_ir_pc", ir_pc, 32'h0);
    rst = 1'b1; ir_ready = 1'b1;
    mi = iss_q.size(); mp = pop_pc_q.size();
    tick(1);
    check("mr_restart_read", bus.read, 1'b1);
    check("mr_restart_addr", bus.address, 32'h0);
    tick(8);
    check("mr_iss0", iss_q[mi], 32'h0);
    check("mr_iss1", iss_q[mi + 1], 32'h4);
    check("mr_pc0", pop_pc_q[mp], 32'h0);
    check("mr_ir0", pop_ir_q[mp], XOR_KEY);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
